// File: rtl/set_count_n.sv
// set_count_n: circle-set point counter.
//
// Latches up to four circles (A..D) and a set-expression mode, then scans every grid point
// (x, y), 1 <= x, y <= GRID, row-major, and counts the points that satisfy the mode. The
// count is presented on candidate together with a one-cycle valid pulse.
//
// Optional feature macro: SET_TWO_PT_EN
//   defined   - two evaluation units, points (x, y) and (x+1, y) per edge; GRID must be even
//   undefined - one point per edge
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   en        in   job request, sampled only while idle
//   central   in   circle centres, set k at [(NSETS-k)*2*COORD_W-1 -: 2*COORD_W], x upper half
//   radius    in   radii, set k at [(NSETS-k)*COORD_W-1 -: COORD_W]
//   mode      in   set expression (0..7), latched with the job
//   busy      out  high while the scan runs
//   valid     out  one-cycle pulse, candidate is final
//   candidate out  point count, held until the next accepted job
module set_count_n #(
  parameter int unsigned GRID    = 8,
  parameter int unsigned NSETS   = 3,
  parameter int unsigned COORD_W = 4,
  localparam int unsigned CNT_W  = $clog2(GRID * GRID + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NSETS*2*COORD_W-1:0] central,
  input  logic [NSETS*COORD_W-1:0]   radius,
  input  logic [2:0]                 mode,
  output logic                       busy,
  output logic                       valid,
  output logic [CNT_W-1:0]           candidate
);

`ifdef SET_TWO_PT_EN
  localparam int unsigned NPT = 2;
  if (GRID % 2 != 0) begin : gen_odd_grid
    $error("set_count_n: GRID must be even when SET_TWO_PT_EN is defined");
  end
`else
  localparam int unsigned NPT = 1;
`endif

  localparam int unsigned DW   = COORD_W + 1;      // signed difference
  localparam int unsigned SQW  = 2 * COORD_W + 2;  // square
  localparam int unsigned SUMW = 2 * COORD_W + 3;  // sum of squares

  localparam logic [COORD_W-1:0] GRID_C   = COORD_W'(GRID);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(GRID - NPT + 1);
  localparam logic [COORD_W-1:0] X_STEP   = COORD_W'(NPT);
  localparam logic [3:0]         SET_MASK = 4'((1 << NSETS) - 1);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e                     state_q;
  logic [COORD_W-1:0]         x_q, y_q;
  logic [NSETS*2*COORD_W-1:0] central_q;
  logic [NSETS*COORD_W-1:0]   radius_q;
  logic [2:0]                 mode_q;

  // (px-cx)^2 + (py-cy)^2 <= r^2, boundary inclusive; widths chosen so nothing overflows.
  function automatic logic in_circle(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                     input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy,
                                     input logic [COORD_W-1:0] r);
    logic signed [DW-1:0]  dx, dy;
    logic signed [SQW-1:0] dxe, dye;
    logic [SQW-1:0]        dx2, dy2;
    logic [SUMW-1:0]       d2, r2;
    dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
    dxe = SQW'(dx);
    dye = SQW'(dy);
    dx2 = $unsigned(dxe * dxe);
    dy2 = $unsigned(dye * dye);
    d2  = SUMW'(dx2) + SUMW'(dy2);
    r2  = SUMW'(r) * SUMW'(r);
    return d2 <= r2;
  endfunction

  // s[k] is membership in set k; sets with index >= NSETS arrive as 0.
  function automatic logic mode_hit(input logic [2:0] m, input logic [3:0] s);
    logic [1:0] n3;
    n3 = {1'b0, s[0]} + {1'b0, s[1]} + {1'b0, s[2]};
    case (m)
      3'd0:    return s[0];
      3'd1:    return s[0] & s[1];
      3'd2:    return s[0] ^ s[1];
      3'd3:    return n3 == 2'd2;
      3'd4:    return s[0] | s[1];
      3'd5:    return s[0] & ~s[1];
      3'd6:    return (s | ~SET_MASK) == 4'hF;
      default: return |s;
    endcase
  endfunction

  logic [NPT-1:0][3:0] member;
  logic [NPT-1:0]      hit;
  logic [CNT_W-1:0]    inc;

  for (genvar p = 0; p < NPT; p++) begin : gen_unit
    logic [COORD_W-1:0] px;
    assign px = x_q + COORD_W'(p);

    for (genvar k = 0; k < 4; k++) begin : gen_set
      if (k < NSETS) begin : gen_used
        localparam int unsigned CTOP = (NSETS - k) * 2 * COORD_W - 1;
        localparam int unsigned RTOP = (NSETS - k) * COORD_W - 1;
        assign member[p][k] = in_circle(px, y_q,
                                        central_q[CTOP -: COORD_W],
                                        central_q[CTOP - COORD_W -: COORD_W],
                                        radius_q[RTOP -: COORD_W]);
      end else begin : gen_empty
        assign member[p][k] = 1'b0;
      end
    end

    assign hit[p] = mode_hit(mode_q, member[p]);
  end

  always_comb begin
    inc = '0;
    for (int p = 0; p < NPT; p++) begin
      inc = inc + CNT_W'(hit[p]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      candidate <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          valid <= 1'b0;
          if (en) begin
            central_q <= central;
            radius_q  <= radius;
            mode_q    <= mode;
            x_q       <= COORD_W'(1);
            y_q       <= COORD_W'(1);
            candidate <= '0;
            busy      <= 1'b1;
            state_q   <= StEval;
          end
        end
        StEval: begin
          candidate <= candidate + inc;
          if (x_q == X_LAST) begin
            x_q <= COORD_W'(1);
            if (y_q == GRID_C) begin
              busy    <= 1'b0;
              valid   <= 1'b1;
              state_q <= StDone;
            end else begin
              y_q <= y_q + COORD_W'(1);
            end
          end else begin
            x_q <= x_q + X_STEP;
          end
        end
        StDone: begin
          valid   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_set_count_n.sv
// Directed bench for set_count_n (GRID=8, NSETS=3, COORD_W=4).
// central packs {Ax, Ay, Bx, By, Cx, Cy}, radius packs {Ar, Br, Cr}, one nibble each.
module tb_set_count_n;

`ifdef SET_TWO_PT_EN
  localparam int SCAN = 32;
`else
  localparam int SCAN = 64;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [2:0]  mode;
  logic        busy;
  logic        valid;
  logic [6:0]  candidate;

  int checks = 0;
  int errors = 0;

  set_count_n #(
    .GRID   (8),
    .NSETS  (3),
    .COORD_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .central  (central),
    .radius   (radius),
    .mode     (mode),
    .busy     (busy),
    .valid    (valid),
    .candidate(candidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ends one time unit after the accepting edge E0.
  task automatic start_job(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m,
                           input string tag);
    @(negedge clk);
    central = c;
    radius  = r;
    mode    = m;
    en      = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_valid"}, valid, 0);
    check({tag, "_start_cand"}, candidate, 0);
  endtask

  // Counts edges until valid, bounded; drops counts samples with neither busy nor valid.
  task automatic wait_valid(output int cyc, output int drops);
    cyc   = 0;
    drops = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (!valid && !busy) drops++;
    end while (!valid && cyc < 200);
  endtask

  task automatic finish_job(input int exp, input string tag);
    int cyc, drops;
    wait_valid(cyc, drops);
    check({tag, "_scan_edges"}, cyc, SCAN);
    check({tag, "_busy_gap"}, drops, 0);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_busy_at_valid"}, busy, 0);
    check({tag, "_cand"}, candidate, exp);
  endtask

  task automatic settle(input int exp, input string tag);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, valid, 0);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_cand_hold"}, candidate, exp);
  endtask

  task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m,
                         input int exp, input string tag);
    start_job(c, r, m, tag);
    finish_job(exp, tag);
    settle(exp, tag);
  endtask

  initial begin
    int cyc, drops;
    rst     = 1'b0;
    en      = 1'b0;
    central = '0;
    radius  = '0;
    mode    = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_cand", candidate, 0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // Disc radius 3 at (4,4): 29 lattice points, all inside the grid.
    run_job(24'h44_00_00, 12'h300, 3'd0, 29, "m0_disc");

    // Intersection of identical discs, then back-to-back request held through DONE.
    start_job(24'h44_44_00, 12'h330, 3'd1, "m1_same");
    finish_job(29, "m1_same");
    @(negedge clk);
    central = 24'h44_88_00;
    radius  = 12'h300;
    mode    = 3'd1;
    en      = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_done_busy", busy, 0);
    check("b2b_done_valid", valid, 0);
    check("b2b_done_cand", candidate, 29);
    @(posedge clk);
    #1;
    en = 1'b0;
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_cand", candidate, 0);
    finish_job(0, "m1_disjoint");
    settle(0, "m1_disjoint");

    // Asynchronous reset in the middle of a scan.
    start_job(24'h44_00_00, 12'h300, 3'd0, "rst_mid");
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_cand", candidate, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rel_busy", busy, 0);
    check("rst_rel_valid", valid, 0);
    check("rst_rel_cand", candidate, 0);

    // Single points (1,1) and (2,2).
    run_job(24'h11_22_00, 12'h000, 3'd2, 2, "m2_xor");
    run_job(24'h11_22_00, 12'h000, 3'd4, 2, "m4_or");
    run_job(24'h11_22_00, 12'h000, 3'd5, 1, "m5_diff");
    // Radius 15 from the corner covers the whole grid.
    run_job(24'h11_00_00, 12'hF00, 3'd7, 64, "m7_full");
    run_job(24'h11_11_11, 12'hFFF, 3'd3, 0, "m3_all3");
    run_job(24'h44_44_44, 12'h333, 3'd6, 29, "m6_all");
    // (1,1) in A and B only, (2,2) in C only.
    run_job(24'h11_11_22, 12'h000, 3'd3, 1, "m3_two");

    // en pulsed mid-scan with different inputs must not disturb the job.
    start_job(24'h44_00_00, 12'h300, 3'd0, "ign");
    repeat (10) @(negedge clk);
    central = 24'h11_00_00;
    radius  = 12'hF00;
    mode    = 3'd7;
    en      = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_valid(cyc, drops);
    check("ign_scan_edges", cyc, SCAN - 10);
    check("ign_busy_gap", drops, 0);
    check("ign_valid", valid, 1);
    check("ign_cand", candidate, 29);
    settle(29, "ign");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_count_n.md
# set_count_n

Parametrised circle-set point counter for the set-evaluation datapath. It accepts up to four circles on an integer grid and one Boolean set mode, then scans every grid point (x, y) with 1 ≤ x, y ≤ GRID. It counts the points that satisfy the mode and returns the count with a one-cycle valid pulse. This is the next generation of the fixed 8×8, three-circle counter, generalised in grid size, circle count, coordinate width and mode set.

## Interface
- GRID, 8, grid side; points 1..GRID on each axis; 2..(2^COORD_W − 1)
- NSETS, 3, number of circles (A, B, C, D); 2..4
- COORD_W, 4, width of each coordinate and radius field
- CNT_W, $clog2(GRID*GRID+1), candidate width (derived localparam)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  job request; sampled only in IDLE
- central  in  NSETS*2*COORD_W  circle centres; set k (A=0) at bits [(NSETS−k)*2*COORD_W−1 -: 2*COORD_W], x in the upper half, y in the lower half
- radius  in  NSETS*COORD_W  radii; set k at bits [(NSETS−k)*COORD_W−1 -: COORD_W]
- mode  in  3  set expression, latched with the job
- busy  out  1  high while the scan runs
- valid  out  1  one-cycle pulse; candidate is final
- candidate  out  CNT_W  point count

## Operation
- Membership of a point in set k: (x−cx)² + (y−cy)² ≤ r². The boundary is inclusive.
- Arithmetic widths:
  - differences are signed, COORD_W+1 bits
  - squares are 2*COORD_W+2 bits
  - the sum is 2*COORD_W+3 bits
  - no overflow occurs for any input value
- Modes:
  - 0: A
  - 1: A∩B
  - 2: A⊕B
  - 3: in exactly two of A, B, C
  - 4: A∪B
  - 5: A∖B
  - 6: in every one of the NSETS sets
  - 7: in at least one of the NSETS sets
- Sets with index ≥ NSETS are empty (for example, C in mode 3 when NSETS=2).
- State machine (IDLE, EVAL, DONE):
  - IDLE → EVAL when en=1. On that edge the block latches central, radius and mode, sets x=y=1, and clears candidate to 0.
  - EVAL scans row-major: x counts 1..GRID, then y increments. Each point is evaluated and added to candidate on the same edge. After the last point the FSM goes to DONE.
  - DONE lasts one cycle, then returns to IDLE.
- en outside IDLE is ignored. Input changes after the latch edge have no effect on the running job.
- candidate holds its value from DONE until the next accepted en.
- Reset values: busy=0, valid=0, candidate=0, state IDLE, scan counters 0.
- Reset asserted mid-operation discards the job immediately and asynchronously. Release returns the block to IDLE.

## Timing
- Edge E0 (IDLE, en=1): latch inputs, busy←1.
- Edges E1..E(GRID²): one point evaluated per edge.
- Edge E(GRID²): busy←0 and valid←1. candidate includes the last point.
- Edge E(GRID²+1): valid←0, return to IDLE. The earliest next acceptance is E(GRID²+2).
- Latency from en to valid: GRID² + 1 edges (65 for GRID=8).
- busy and valid are never high together.

## Configuration
- SET_TWO_PT_EN defined:
  - two evaluation units process points (x, y) and (x+1, y) per edge
  - candidate increments by 0, 1 or 2
  - the scan takes GRID²/2 edges; valid rises at E(GRID²/2)
  - GRID must be even; an elaboration check fails otherwise
- SET_TWO_PT_EN undefined: one point per edge, as in Timing.
- The count result is identical in both builds.

## Test plan
- Mode 0, GRID=8, A at (4,4), r=3 → busy high for 64 cycles, valid one cycle later, candidate=29, valid low after one cycle.
- Mode 1, A at (4,4) r=3 and B identical → 29. Then B at (8,8) r=0 → 0.
- Mode 2, A at (1,1) r=0 and B at (2,2) r=0 → 2. Same circles in mode 4 → 2. Same circles in mode 5 → 1.
- Mode 7, A at (1,1) r=15 → 64 (full-scale count, CNT_W=7). Mode 3 with A=B=C at (1,1) r=15 → 0.
- Reset low at EVAL cycle 20 → busy, valid and candidate all 0 before the next edge. en pulsed during a busy job → ignored, result unchanged.
- SET_TWO_PT_EN build, scenario 1 stimulus → busy high for 32 cycles, candidate=29.
